// File: rtl/led_fade_pkg.sv
// Shared types and helpers for the LED fade driver.
// The optional LED_GAMMA_EN macro (used by led_fade_channel) selects the squared duty curve.
package led_fade_pkg;

  localparam int PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  // Direction a channel's level moves on the current fade tick.
  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN
  } dir_t;

  // Full-scale level for a given counter width.
  function automatic int unsigned lvl_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating level register, duty mapping and registered PWM output.
// Define LED_GAMMA_EN to map duty = level^2 >> PWM_BITS (full scale kept at full scale);
// otherwise duty = level and no multiplier is built.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                tgt,
  input  logic                fade_en,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));

  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] duty;
  logic                led_reg;
  logic                led_next;
  dir_t                dir;

  // Pick the step direction; only a tick can move the level, and it saturates at both ends.
  always_comb begin
    dir = HOLD;
    if (tick) begin
      if (tgt && (level_reg != LVL_MAX)) begin
        dir = UP;
      end else if (!tgt && (level_reg != '0)) begin
        dir = DOWN;
      end
    end
  end

  // Next level: snap straight to the target extreme when fading is off, else step.
  always_comb begin
    level_next = level_reg;
    if (!fade_en) begin
      level_next = tgt ? LVL_MAX : '0;
    end else begin
      case (dir)
        UP:      level_next = level_reg + PWM_BITS'(1);
        DOWN:    level_next = level_reg - PWM_BITS'(1);
        default: level_next = level_reg;
      endcase
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;

  // Squared duty curve for a perceptually even fade; full scale stays fully on.
  always_comb begin
    level_sq = {{PWM_BITS{1'b0}}, level_reg} * {{PWM_BITS{1'b0}}, level_reg};
    duty     = (level_reg == LVL_MAX) ? LVL_MAX : PWM_BITS'(level_sq >> PWM_BITS);
  end
`else
  // Linear duty curve.
  always_comb begin
    duty = level_reg;
  end
`endif

  // Comparator; full scale is forced high so there is no dropout when pwm_cnt wraps.
  always_comb begin
    led_next = (duty == LVL_MAX) || (duty > pwm_cnt);
  end

  // Level and LED output registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      level_reg <= '0;
      led_reg   <= 1'b0;
    end else begin
      level_reg <= level_next;
      led_reg   <= led_next;
    end
  end

  assign level = level_reg;
  assign led   = led_reg;

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: registers the PIO LED pattern, fades each channel's brightness
// toward it one step per fade tick and renders the result through a shared PWM counter.
// Optional build macro LED_GAMMA_EN selects the squared duty curve in each channel.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = 50000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_LEDS-1:0] leds_export,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_o,
  output logic                fade_busy
);

  localparam int                  DIV_W    = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = PWM_BITS'(lvl_max(PWM_BITS));

  logic [NUM_LEDS-1:0] tgt_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                fade_busy_reg;
  logic                fade_busy_next;
  logic [NUM_LEDS-1:0] led_w;
  logic [NUM_LEDS-1:0] mismatch;
  logic [PWM_BITS-1:0] level_w [NUM_LEDS];

  assign tick = (div_cnt == DIV_LAST);

  // Target register, fade tick divider and free-running PWM counter.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tgt_q         <= '0;
      div_cnt       <= '0;
      pwm_cnt       <= '0;
      fade_busy_reg <= 1'b0;
    end else begin
      tgt_q         <= leds_export;
      div_cnt       <= tick ? '0 : div_cnt + DIV_W'(1);
      pwm_cnt       <= pwm_cnt + PWM_BITS'(1);
      fade_busy_reg <= fade_busy_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : gen_ch
      led_fade_channel #(
        .PWM_BITS(PWM_BITS)
      ) u_ch (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .tgt        (tgt_q[gi]),
        .fade_en    (fade_en),
        .tick       (tick),
        .pwm_cnt    (pwm_cnt),
        .level      (level_w[gi]),
        .led        (led_w[gi])
      );
      assign mismatch[gi] = (level_w[gi] != (tgt_q[gi] ? LVL_MAX : '0));
    end
  endgenerate

  // Busy while any level is still away from its target. In snap mode a level trails
  // tgt_q by only one cycle and no fade is in progress, so busy is held low there.
  always_comb begin
    fade_busy_next = fade_en && (|mismatch);
  end

  assign led_o     = led_w;
  assign fade_busy = fade_busy_reg;

endmodule
